// File: rtl/spi_master_mc_pkg.sv
// Shared types for the multi-slave SPI master: FSM state encoding and per-transaction mode.
// Pure declarations; no logic, no latency, no flow control.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_master_mc_sclk_gen.sv
// SCLK divider: one lead/trail strobe every CLK_DIVIDER cycles while enabled; sclk = cpol ^ phase.
// Strobes are combinational from the counter flop; disabling clears counter and phase.
module spi_sclk_gen #(
  parameter int CLK_DIVIDER = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cpol,
  output logic lead_edge,
  output logic trail_edge,
  output logic sclk
);

  localparam int CNT_W = (CLK_DIVIDER > 1) ? $clog2(CLK_DIVIDER) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             strobe;

  always_comb begin
    strobe     = en && (cnt_q == CNT_W'(CLK_DIVIDER - 1));
    lead_edge  = strobe && !phase_q;
    trail_edge = strobe && phase_q;
    cnt_d      = '0;
    phase_d    = 1'b0;
    if (en) begin
      cnt_d   = strobe ? '0 : cnt_q + 1'b1;
      phase_d = phase_q ^ strobe;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign sclk = cpol ^ phase_q;

endmodule

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master, per-transaction CPOL/CPHA/bit order; done (2*DATA_W+2)*CLK_DIVIDER+1 cycles after accept.
// One transfer in flight: start is taken only while ready=1. Debug taps under SPI_MASTER_DEBUG_EN.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int  DATA_W      = 8,
  parameter int  NUM_SS      = 4,
  parameter int  CLK_DIVIDER = 4,
  localparam int SEL_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_transaction,
  output logic              ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  output logic [DATA_W-1:0] rx_data,
  output logic              transaction_done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
`ifdef SPI_MASTER_DEBUG_EN
  output logic [1:0]              state_o,
  output logic [$clog2(DATA_W)-1:0] bit_count_o,
  output logic [DATA_W-1:0]       rx_shift_o,
`endif
  output logic [NUM_SS-1:0] ss_n
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int EC_W  = $clog2(2 * DATA_W + 1);
  localparam int CNT_W = (CLK_DIVIDER > 1) ? $clog2(CLK_DIVIDER) : 1;

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              mosi_q, mosi_d;

  logic              gen_en, lead_edge, trail_edge;
  logic              sample_edge, drive_edge;
  logic [EC_W-1:0]   next_bit;

  function automatic logic [IDX_W-1:0] bit_pos(input logic [EC_W-1:0] k, input logic lsb);
    logic [IDX_W-1:0] i;
    i = k[IDX_W-1:0];
    return lsb ? i : IDX_W'(DATA_W - 1) - i;
  endfunction

  // Out-of-range selects yield an all-high mask, so the transfer runs with no slave selected.
  function automatic logic [NUM_SS-1:0] sel_mask(input logic [SEL_W-1:0] sel);
    logic [NUM_SS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(sel) == i) m[i] = 1'b0;
    end
    return m;
  endfunction

  // The edge counter saturating at 2*DATA_W also stops the divider, giving sclk one rest cycle before HOLD.
  assign gen_en = (state_q == TRANSFER) && (edge_cnt_q != EC_W'(2 * DATA_W));

  spi_sclk_gen #(.CLK_DIVIDER(CLK_DIVIDER)) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (gen_en),
    .cpol       (mode_q.cpol),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sclk       (sclk)
  );

  always_comb begin
    sample_edge = mode_q.cpha ? trail_edge : lead_edge;
    drive_edge  = mode_q.cpha ? lead_edge : trail_edge;
    next_bit    = (edge_cnt_q + EC_W'(1)) >> 1;

    state_d    = state_q;
    mode_d     = mode_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    cyc_cnt_d  = '0;
    edge_cnt_d = edge_cnt_q;
    ss_n_d     = ss_n_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    mosi_d     = mosi_q;

    case (state_q)
      IDLE: begin
        if (start_transaction) begin
          mode_d     = '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
          tx_d       = tx_data;
          rx_shift_d = '0;
          edge_cnt_d = '0;
          ss_n_d     = sel_mask(ss_sel);
          ready_d    = 1'b0;
          state_d    = SETUP;
          if (!cpha) mosi_d = tx_data[bit_pos(EC_W'(0), lsb_first)];
        end
      end
      SETUP: begin
        if (cyc_cnt_q == CNT_W'(CLK_DIVIDER - 1)) state_d = TRANSFER;
        else cyc_cnt_d = cyc_cnt_q + 1'b1;
      end
      TRANSFER: begin
        if (edge_cnt_q == EC_W'(2 * DATA_W)) begin
          state_d = HOLD;
        end else if (lead_edge || trail_edge) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
          if (sample_edge) begin
            rx_shift_d = mode_q.lsb_first ? {miso, rx_shift_q[DATA_W-1:1]}
                                          : {rx_shift_q[DATA_W-2:0], miso};
          end
          if (drive_edge && (next_bit < EC_W'(DATA_W))) begin
            mosi_d = tx_q[bit_pos(next_bit, mode_q.lsb_first)];
          end
        end
      end
      HOLD: begin
        if (cyc_cnt_q == CNT_W'(CLK_DIVIDER - 1)) begin
          state_d   = IDLE;
          ss_n_d    = '1;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          ready_d   = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      tx_q       <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      cyc_cnt_q  <= '0;
      edge_cnt_q <= '0;
      ss_n_q     <= '1;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      cyc_cnt_q  <= cyc_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ss_n_q     <= ss_n_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      mosi_q     <= mosi_d;
    end
  end

  assign ready            = ready_q;
  assign rx_data          = rx_data_q;
  assign transaction_done = done_q;
  assign mosi             = mosi_q;
  assign ss_n             = ss_n_q;

`ifdef SPI_MASTER_DEBUG_EN
  assign state_o     = state_q;
  assign bit_count_o = IDX_W'(edge_cnt_q >> 1);
  assign rx_shift_o  = rx_shift_q;
`endif

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc (DATA_W=8, NUM_SS=4, CLK_DIVIDER=4): vector table, SPI slave model, scoreboard queue.
module tb_spi_master_mc;

  localparam int DW  = 8;
  localparam int NSS = 4;
  localparam int DIV = 4;
  localparam int LAT = (2 * DW + 2) * DIV + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_transaction = 1'b0;
  logic [DW-1:0]  tx_data = '0;
  logic [1:0]     ss_sel = '0;
  logic           cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic           miso = 1'b0;
  logic           ready, transaction_done, sclk, mosi;
  logic [DW-1:0]  rx_data;
  logic [NSS-1:0] ss_n;
`ifdef SPI_MASTER_DEBUG_EN
  logic [1:0]     state_o;
  logic [2:0]     bit_count_o;
  logic [DW-1:0]  rx_shift_o;
`endif

  always #5 clk = ~clk;

  spi_master_mc #(.DATA_W(DW), .NUM_SS(NSS), .CLK_DIVIDER(DIV)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_transaction (start_transaction),
    .ready             (ready),
    .tx_data           (tx_data),
    .ss_sel            (ss_sel),
    .cpol              (cpol),
    .cpha              (cpha),
    .lsb_first         (lsb_first),
    .rx_data           (rx_data),
    .transaction_done  (transaction_done),
    .sclk              (sclk),
    .mosi              (mosi),
    .miso              (miso),
`ifdef SPI_MASTER_DEBUG_EN
    .state_o           (state_o),
    .bit_count_o       (bit_count_o),
    .rx_shift_o        (rx_shift_o),
`endif
    .ss_n              (ss_n)
  );

  typedef struct {
    logic [7:0] tx;
    logic [1:0] sel;
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic [7:0] slv;
  } vec_t;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] mosi;
    logic [3:0] ss;
    logic       cpol;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[4];
  int   n_vec = 0;
  int   n_bad = 0;

  // Slave configuration (written by the stimulus) and slave model state.
  logic [7:0] cfg_word = '0;
  logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
  logic [7:0] sl_word = '0;
  logic [7:0] mosi_seen = '0;
  int         sl_idx = 0;
  logic       sclk_prev = 1'b0;
  logic [3:0] ss_prev = 4'hF;

  function automatic logic bitof(input logic [7:0] w, input int i, input logic lsb);
    return lsb ? w[i] : w[7-i];
  endfunction

  function automatic int posof(input int i, input logic lsb);
    return lsb ? i : 7 - i;
  endfunction

  always @(negedge clk) begin
    sclk_prev <= sclk;
    ss_prev   <= ss_n;
    if (ss_prev == 4'hF && ss_n != 4'hF) begin
      sl_word   <= cfg_word;
      sl_idx    <= 0;
      mosi_seen <= '0;
      if (!cfg_cpha) miso <= bitof(cfg_word, 0, cfg_lsb);
    end else if (ss_n != 4'hF && sclk != sclk_prev && sl_idx < 8) begin
      if (sclk != cfg_cpol) begin
        if (cfg_cpha) miso <= bitof(sl_word, sl_idx, cfg_lsb);
        else mosi_seen[posof(sl_idx, cfg_lsb)] <= mosi;
      end else begin
        if (cfg_cpha) mosi_seen[posof(sl_idx, cfg_lsb)] <= mosi;
        else if (sl_idx < 7) miso <= bitof(sl_word, sl_idx + 1, cfg_lsb);
        sl_idx <= sl_idx + 1;
      end
    end
  end

  // Bus monitor: AND of ss_n per transfer epoch, and running count of done pulses.
  int         mon_epoch = 0;
  int         seen_epoch = 0;
  logic [3:0] ss_and = 4'hF;
  int         done_total = 0;

  always @(negedge clk) begin
    if (mon_epoch != seen_epoch) begin
      ss_and     <= ss_n;
      seen_epoch <= mon_epoch;
    end else begin
      ss_and <= ss_and & ss_n;
    end
    if (transaction_done) done_total <= done_total + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_xfer(input vec_t v, input bit hold_start);
    exp_t e;
    @(negedge clk);
    chk("ready_before_start", {31'd0, ready}, 32'd1);
    tx_data = v.tx; ss_sel = v.sel; cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb;
    cfg_word = v.slv; cfg_cpol = v.cpol; cfg_cpha = v.cpha; cfg_lsb = v.lsb;
    start_transaction = 1'b1;
    e.rx = v.slv; e.mosi = v.tx; e.cpol = v.cpol;
    e.ss = 4'hF & ~(4'h1 << v.sel);
    sb.push_back(e);
    @(posedge clk); #1;
    if (!hold_start) start_transaction = 1'b0;
    mon_epoch++;
  endtask

  task automatic finish_xfer(input int exp_lat, output logic cpol_exp);
    int   lat;
    bit   rdy_early;
    exp_t e;
    lat = -1;
    rdy_early = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (transaction_done) begin
        lat = k;
        break;
      end
      if (ready) rdy_early = 1'b1;
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      cpol_exp = 1'b0;
    end else begin
      e = sb.pop_front();
      cpol_exp = e.cpol;
      chk("latency", lat, exp_lat);
      chk("rx_data", {24'd0, rx_data}, {24'd0, e.rx});
      chk("mosi_word", {24'd0, mosi_seen}, {24'd0, e.mosi});
      chk("ss_n_during", {28'd0, ss_and}, {28'd0, e.ss});
      chk("ready_while_busy", {31'd0, rdy_early}, 32'd0);
      chk("ready_at_done", {31'd0, ready}, 32'd1);
      chk("ss_n_at_done", {28'd0, ss_n}, 32'hF);
    end
  endtask

  task automatic tail_checks(input logic exp_cpol);
    @(posedge clk); #1;
    chk("done_single_cycle", {31'd0, transaction_done}, 32'd0);
    chk("sclk_idle_level", {31'd0, sclk}, {31'd0, exp_cpol});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t junk;
    logic c;
    int   done_before;

    vecs[0] = '{tx: 8'hA5, sel: 2'd2, cpol: 1'b0, cpha: 1'b0, lsb: 1'b0, slv: 8'h3C};
    vecs[1] = '{tx: 8'h81, sel: 2'd1, cpol: 1'b1, cpha: 1'b1, lsb: 1'b1, slv: 8'h5A};
    vecs[2] = '{tx: 8'hC3, sel: 2'd3, cpol: 1'b0, cpha: 1'b1, lsb: 1'b0, slv: 8'h96};
    vecs[3] = '{tx: 8'h5E, sel: 2'd0, cpol: 1'b1, cpha: 1'b0, lsb: 1'b1, slv: 8'hE7};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_ss_n", {28'd0, ss_n}, 32'hF);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_done", {31'd0, transaction_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      start_xfer(vecs[i], 1'b0);
      finish_xfer(LAT, c);
      tail_checks(c);
    end

    // A start pulse twenty cycles into a transfer must be dropped.
    done_before = done_total;
    v = '{tx: 8'h69, sel: 2'd1, cpol: 1'b0, cpha: 1'b0, lsb: 1'b0, slv: 8'hB4};
    start_xfer(v, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    start_transaction = 1'b1;
    tx_data = 8'hEE;
    @(negedge clk);
    start_transaction = 1'b0;
    finish_xfer(LAT - 20, c);
    tail_checks(c);
    repeat (100) @(posedge clk);
    #1;
    chk("ignored_start_done_count", done_total - done_before, 32'd1);
    chk("ignored_start_ready", {31'd0, ready}, 32'd1);

    // Asynchronous reset around bit 4 of a mode-3 transfer.
    v = '{tx: 8'h3F, sel: 2'd2, cpol: 1'b1, cpha: 1'b1, lsb: 1'b0, slv: 8'h5A};
    start_xfer(v, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ss_n", {28'd0, ss_n}, 32'hF);
    chk("midrst_sclk", {31'd0, sclk}, 32'd0);
    chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_mosi", {31'd0, mosi}, 32'd0);
    if (sb.size() > 0) junk = sb.pop_back();
    @(negedge clk);
    rst_n = 1'b1;
    v = '{tx: 8'hFF, sel: 2'd1, cpol: 1'b0, cpha: 1'b0, lsb: 1'b0, slv: 8'hC5};
    start_xfer(v, 1'b0);
    finish_xfer(LAT, c);
    tail_checks(c);

    // Back-to-back: start held high across the first done pulse.
    v = '{tx: 8'h11, sel: 2'd1, cpol: 1'b0, cpha: 1'b0, lsb: 1'b0, slv: 8'h9D};
    start_xfer(v, 1'b1);
    finish_xfer(LAT, c);
    tx_data = 8'h22; ss_sel = 2'd1;
    cfg_word = 8'h4B;
    junk.rx = 8'h4B; junk.mosi = 8'h22; junk.ss = 4'b1101; junk.cpol = 1'b0;
    sb.push_back(junk);
    @(posedge clk); #1;
    start_transaction = 1'b0;
    mon_epoch++;
    chk("b2b_ss_reasserted", {28'd0, ss_n}, 32'hD);
    chk("b2b_ready_low", {31'd0, ready}, 32'd0);
    finish_xfer(LAT, c);
    tail_checks(c);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
Parametrised multi-slave SPI master, successor to the 8-bit fixed-mode spi_master.
- Data width is a parameter. Slave-select count is a parameter.
- SPI mode (CPOL/CPHA) and bit order are selected per transaction.
- Exposes a ready/start handshake and a one-cycle done pulse.
- Sits between a register/bus front end and off-chip SPI peripherals.

Parameters:
- DATA_W, 8: bits per transaction (>=2).
- NUM_SS, 4: number of active-low slave selects (>=1).
- CLK_DIVIDER, 4: clk cycles per SCLK half-period (>=1).
- SEL_W, $clog2(NUM_SS) (min 1): width of ss_sel (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_transaction  in  1  request; accepted only when ready=1.
- ready  out  1  high in IDLE only.
- tx_data  in  DATA_W  word to send; latched on accept.
- ss_sel  in  SEL_W  target slave; latched on accept.
- cpol  in  1  clock polarity; latched on accept.
- cpha  in  1  clock phase; latched on accept.
- lsb_first  in  1  bit order; latched on accept.
- rx_data  out  DATA_W  received word; updated with transaction_done.
- transaction_done  out  1  single-cycle pulse at end of transfer.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- ss_n  out  NUM_SS  one-hot-low slave selects.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer): state=IDLE, ready=1, sclk=0, mosi=0, ss_n=all 1, rx_data=0, transaction_done=0, latched mode=0, all counters=0.
- Accept: in IDLE, start_transaction=1 at a rising edge latches tx_data, ss_sel, cpol, cpha and lsb_first, then moves to SETUP. start_transaction outside IDLE is ignored; no queuing.
- IDLE: sclk=latched cpol (0 after reset); ss_n all 1; mosi holds its last value.
- SETUP (CLK_DIVIDER cycles):
  - ss_n[ss_sel]=0, sclk=cpol.
  - CPHA=0: first data bit driven on mosi at SETUP entry.
  - If ss_sel>=NUM_SS, the transfer still runs and completes with all ss_n high.
- TRANSFER: 2*DATA_W SCLK edges, one every CLK_DIVIDER cycles.
  - CPHA=0: sample miso on leading edges; drive next bit on trailing edges (no drive after the last edge).
  - CPHA=1: drive bit on leading edges; sample on trailing edges.
  - Bit order: MSB first unless lsb_first=1. The rx shift fills in the same order, so rx_data is always in natural bit order.
  - After the 2*DATA_W-th edge, sclk rests at cpol; go to HOLD.
- HOLD (CLK_DIVIDER cycles): ss_n stays asserted. On exit: ss_n all 1, rx_data<=shift register, transaction_done=1 for one cycle, state=IDLE, ready=1.
- Latency: transaction_done is asserted exactly (2*DATA_W+2)*CLK_DIVIDER+1 cycles after the accepting edge.
- Back-to-back: start may be asserted in the same cycle as transaction_done; it is accepted on the following edge (ready=1). Minimum ss_n high gap is 1 cycle.
- State encoding: 2 bits, IDLE=0, SETUP=1, TRANSFER=2, HOLD=3.

Optional Feature:
- SPI_MASTER_DEBUG_EN defined: adds outputs state_o[1:0], bit_count_o[$clog2(DATA_W)-1:0] (current bit index) and rx_shift_o[DATA_W-1:0] (live shift register).
- Undefined: these ports do not exist; functional behaviour is identical.

Decomposition:
- Package spi_pkg: spi_state_e enum (IDLE, SETUP, TRANSFER, HOLD) and spi_mode_t struct {cpol, cpha, lsb_first}.
- Sub-module spi_sclk_gen:
  - Divider counter. Emits lead_edge/trail_edge strobes and the sclk level given cpol.
  - Enabled only in TRANSFER.
  - Reset and restart clear its counter.

Test Plan (DATA_W=8, NUM_SS=4, CLK_DIVIDER=4):
- Mode 0, tx 0xA5, ss_sel=2, slave model returns 0x3C -> ss_n=4'b1011 during transfer; mosi bits 1,0,1,0,0,1,0,1 sampled on rising sclk; rx_data=0x3C; done 73 cycles after accept.
- Mode 3 (cpol=1, cpha=1), lsb_first=1, tx 0x81, miso returns 0x5A LSB-first -> sclk idles high; mosi 1,0,0,0,0,0,0,1; rx_data=0x5A.
- start_transaction pulsed at cycle 20 of a transfer -> ignored; exactly one done pulse; ready stays 0 until done.
- rst_n low at bit 4 -> ss_n=4'b1111, sclk=0, rx_data=0x00 immediately; new transfer with tx 0xFF completes normally.
- Back-to-back: start held high across done, tx 0x11 then 0x22 -> two done pulses 74 cycles apart; ss_n high for exactly 1 cycle between them.
- ss_sel=3 then ss_sel=0 -> only ss_n[3] then only ss_n[0] low; other selects never asserted.
